// File: rtl/num_string_renderer_if.sv
// num_string_renderer_if: pixel coordinates, value load controls and render outputs of the digit-string renderer
// Ports (master = VGA/control side, slave = renderer):
//   pixel_x, pixel_y, video_on  pixel stream from the VGA timing generator
//   frame_start, load, digits_in  frame pulse and value capture
//   pixel_on, pixel_valid, update_pending  render outputs
//   blink_mask  only when NUM_STRING_RENDERER_BLINK_EN is defined
interface num_string_renderer_if #(parameter int NUM_DIGITS = 4);
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic video_on;
  logic frame_start;
  logic load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic pixel_on;
  logic pixel_valid;
  logic update_pending;
`ifdef NUM_STRING_RENDERER_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_mask;
`endif
  modport master(
`ifdef NUM_STRING_RENDERER_BLINK_EN
    output blink_mask,
`endif
    output pixel_x, pixel_y, video_on, frame_start, load, digits_in,
    input pixel_on, pixel_valid, update_pending
  );
  modport slave(
`ifdef NUM_STRING_RENDERER_BLINK_EN
    input blink_mask,
`endif
    input pixel_x, pixel_y, video_on, frame_start, load, digits_in,
    output pixel_on, pixel_valid, update_pending
  );
endinterface

// File: rtl/num_string_renderer.sv
// num_string_renderer: renders a NUM_DIGITS character string (0-9, minus, blank) as a registered per-pixel on bit
// Ports: clk, reset (sync, active-high), bus (num_string_renderer_if.slave).
// Optional macro NUM_STRING_RENDERER_BLINK_EN adds bus.blink_mask and a 16-frame blink for masked cells.
module num_string_renderer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int ORIGIN_X = 100,
  parameter int ORIGIN_Y = 50,
  parameter int LZB = 1
) (
  input logic clk,
  input logic reset,
  num_string_renderer_if.slave bus
);
  localparam int CW = 6 << SCALE_LOG2;
  localparam int CH = 6 << SCALE_LOG2;
  localparam int DB = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int W = 4 * NUM_DIGITS;
  logic [W-1:0] display, pending;
  logic upd;
  always_ff @(posedge clk)
    if (reset) begin
      display <= '1;
      pending <= '1;
      upd <= 1'b0;
    end else if (bus.load && bus.frame_start) begin
      display <= bus.digits_in;
      upd <= 1'b0;
    end else if (bus.load) begin
      pending <= bus.digits_in;
      upd <= 1'b1;
    end else if (bus.frame_start && upd) begin
      display <= pending;
      upd <= 1'b0;
    end
  logic [NUM_DIGITS-1:0] blink_off;
`ifdef NUM_STRING_RENDERER_BLINK_EN
  logic [4:0] frame_cnt;
  always_ff @(posedge clk)
    if (reset) frame_cnt <= '0;
    else if (bus.frame_start) frame_cnt <= frame_cnt + 5'd1;
  assign blink_off = frame_cnt[4] ? bus.blink_mask : '0;
`else
  assign blink_off = '0;
`endif
  // Effective code per digit (index 0 = LSD); leading zeros and blinked cells become blank at render time only
  logic [3:0] eff [NUM_DIGITS];
  always_comb begin
    logic lz;
    lz = (LZB != 0);
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      lz = lz && display[4*d +: 4] == 4'd0 && d != 0;
      eff[d] = (lz || blink_off[d]) ? 4'hF : display[4*d +: 4];
    end
  end
  int rx, ry;
  logic in_region;
  assign rx = int'(bus.pixel_x) - ORIGIN_X;
  assign ry = int'(bus.pixel_y) - ORIGIN_Y;
  assign in_region = rx >= 0 && rx < NUM_DIGITS * CW && ry >= 0 && ry < CH;
  logic s1_in, s1_vid;
  logic [DB-1:0] s1_dig;
  logic [2:0] s1_col, s1_row;
  always_ff @(posedge clk)
    if (reset) begin
      s1_in <= 1'b0;
      s1_vid <= 1'b0;
      s1_dig <= '0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_in <= in_region;
      s1_vid <= bus.video_on;
      s1_dig <= in_region ? DB'(NUM_DIGITS - 1 - rx / CW) : '0;
      s1_col <= 3'((rx % CW) >> SCALE_LOG2);
      s1_row <= 3'(ry >> SCALE_LOG2);
    end
  logic [3:0] code;
  logic [29:0] g;
  logic [4:0] bits;
  logic [7:0] sh;
  assign code = eff[s1_dig];
  // Six 5-bit rows packed MSB-first: row 0 (top) in [29:25], bit 4 of each row is the leftmost column
  always_comb
    case (code)
      4'd0: g = 30'b01110_10001_10001_10001_10001_01110;
      4'd1: g = 30'b00100_01100_00100_00100_00100_01110;
      4'd2: g = 30'b01110_10001_01000_00100_00010_11111;
      4'd3: g = 30'b11110_00001_01110_00001_00001_11110;
      4'd4: g = 30'b10010_10010_10010_11111_00010_00010;
      4'd5: g = 30'b11111_10000_11110_00001_00001_11110;
      4'd6: g = 30'b01110_10000_11110_10001_10001_01110;
      4'd7: g = 30'b11111_00001_00010_00100_01000_01000;
      4'd8: g = 30'b01110_10001_01110_10001_10001_01110;
      4'd9: g = 30'b01110_10001_10001_01111_00001_01110;
      4'hA: g = 30'b00000_00000_00000_11111_00000_00000;
      default: g = '0;
    endcase
  assign bits = 5'(g >> (5 * (3'd5 - s1_row)));
  // Shifting left by col brings the addressed column to bit 4; the gap column (col 5) shifts in a zero
  assign sh = {3'b000, bits} << s1_col;
  logic pon, pval;
  always_ff @(posedge clk)
    if (reset) begin
      pon <= 1'b0;
      pval <= 1'b0;
    end else begin
      pon <= s1_in & s1_vid & (s1_col < 3'd5) & sh[4];
      pval <= s1_vid;
    end
  assign bus.pixel_on = pon;
  assign bus.pixel_valid = pval;
  assign bus.update_pending = upd;
endmodule
